shift_lfsr8: RTL and testbench

- 8-bit register that performs one shift-register operation per debounced button press.
- Includes an 8-bit LFSR random mode.
- Drives the board LEDs directly.
- Splits its value into two 4-bit nibbles that feed two downstream 7-segment hex decoder instances (high digit, low digit).

---
 rtl/shift_lfsr8_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 55 +++++
 rtl/shift_lfsr8.sv | 61 ++++++
 tb/tb_shift_lfsr8.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_lfsr8_pkg.sv
// rtl/shift_lfsr8_pkg.sv - operation encodings and LFSR constants for shift_lfsr8
package shift_lfsr8_pkg;

   typedef enum logic [2:0] {
      OP_CLR  = 3'd0,
      OP_LOAD = 3'd1,
      OP_SRL  = 3'd2,
      OP_SLL  = 3'd3,
      OP_SRA  = 3'd4,
      OP_SIN  = 3'd5,
      OP_ROR  = 3'd6,
      OP_LFSR = 3'd7
   } op_e;

   localparam logic [7:0] LFSR_TAPS   = 8'b0001_1101;
   localparam logic [7:0] LFSR_ESCAPE = 8'h01;

   // The all-zero state is a fixed point of the feedback, so it is forced out.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      if (cur == 8'h00) begin
         return LFSR_ESCAPE;
      end
      return {^(cur & LFSR_TAPS), cur[7:1]};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and press pulse generator
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;

   always_comb begin
      s1_d    = btn;
      s2_d    = s1_q;
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      // The count only survives while the synchronised input disagrees with the accepted level.
      if (s2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = s2_q;
            rise_d  = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/shift_lfsr8.sv
// rtl/shift_lfsr8.sv - 8-bit shift/LFSR register stepped by a debounced button
module shift_lfsr8
   import shift_lfsr8_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 1000000,
   parameter logic [7:0]  RESET_VALUE     = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   input  logic [2:0] op,
   input  logic [7:0] din,
   input  logic       sin,
   output logic [7:0] q,
   output logic [3:0] nib_hi,
   output logic [3:0] nib_lo,
   output logic       step_o
);

   logic [7:0] q_q, q_d;
   logic       step;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn),
      .rise_o(step)
   );

   always_comb begin
      q_d = q_q;
      if (step) begin
         case (op)
            OP_CLR:  q_d = 8'h00;
            OP_LOAD: q_d = din;
            OP_SRL:  q_d = {1'b0, q_q[7:1]};
            OP_SLL:  q_d = {q_q[6:0], 1'b0};
            OP_SRA:  q_d = {q_q[7], q_q[7:1]};
            OP_SIN:  q_d = {sin, q_q[7:1]};
            OP_ROR:  q_d = {q_q[0], q_q[7:1]};
            OP_LFSR: q_d = lfsr_next(q_q);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign q      = q_q;
   assign nib_hi = q_q[7:4];
   assign nib_lo = q_q[3:0];
   assign step_o = step;

endmodule

// File: tb/tb_shift_lfsr8.sv
// tb/tb_shift_lfsr8.sv - self-checking bench for shift_lfsr8
module tb_shift_lfsr8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic [2:0] op  = 3'd0;
   logic [7:0] din = 8'h00;
   logic       sin = 1'b0;
   logic [7:0] q;
   logic [3:0] nib_hi, nib_lo;
   logic       step_o;

   int total = 0;
   int bad   = 0;
   logic [7:0] model_q = 8'h00;

   shift_lfsr8 #(.DEBOUNCE_CYCLES(4), .RESET_VALUE(8'h00)) dut (
      .clk(clk), .rst(rst), .btn(btn), .op(op), .din(din), .sin(sin),
      .q(q), .nib_hi(nib_hi), .nib_lo(nib_lo), .step_o(step_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference: arithmetic reading of each operation, not bit slicing.
   function automatic logic [7:0] ref_next(input int o, input int cur, input int d, input int s);
      int r;
      case (o)
         0: r = 0;
         1: r = d;
         2: r = cur / 2;
         3: r = (cur * 2) % 256;
         4: r = cur / 2 + ((cur >= 128) ? 128 : 0);
         5: r = cur / 2 + s * 128;
         6: r = cur / 2 + (cur % 2) * 128;
         default: r = (cur == 0) ? 1 : cur / 2 + ($countones(cur & 8'h1D) % 2) * 128;
      endcase
      return 8'(r);
   endfunction

   task automatic press(input logic [2:0] o, input logic [7:0] d, input logic s,
                        input bit bounce, input int hold, input string nm);
      int step_edge;
      int pulses;
      logic [7:0] old_q, exp_q;
      old_q = model_q;
      exp_q = ref_next(int'(o), int'(model_q), int'(d), int'(s));
      op = o; din = d; sin = s;
      pulses = 0;
      if (bounce) begin
         for (int k = 0; k < 4; k++) begin
            btn = (k % 2 == 0);
            tick();
            if (step_o) pulses++;
         end
         chk({nm, "_bounce_pulse"}, pulses, 0);
      end
      btn = 1'b1;
      step_edge = -1;
      pulses = 0;
      for (int e = 1; e <= hold; e++) begin
         tick();
         if (step_o) begin
            pulses++;
            if (step_edge < 0) step_edge = e;
         end
         if (e == 6) chk({nm, "_q_before"}, int'(q), int'(old_q));
         if (e == 7) begin
            chk({nm, "_q"}, int'(q), int'(exp_q));
            chk({nm, "_nib_hi"}, int'(nib_hi), int'(exp_q) / 16);
            chk({nm, "_nib_lo"}, int'(nib_lo), int'(exp_q) % 16);
            op = 3'($urandom); din = 8'($urandom); sin = 1'($urandom);
         end
      end
      chk({nm, "_step_edge"}, step_edge, 6);
      chk({nm, "_pulses"}, pulses, 1);
      btn = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (step_o) pulses++;
      end
      chk({nm, "_release_pulse"}, pulses, 0);
      chk({nm, "_q_hold"}, int'(q), int'(exp_q));
      model_q = exp_q;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] din;
      logic       sin;
      logic [7:0] exp;
   } vec_t;

   vec_t sweep[7];
   logic [7:0] lfsr_seq[6];
   bit saw_zero;
   int step_edge;
   int pulses;

   initial begin
      sweep[0] = '{3'd1, 8'hB4, 1'b0, 8'hB4};
      sweep[1] = '{3'd2, 8'h00, 1'b0, 8'h5A};
      sweep[2] = '{3'd3, 8'h00, 1'b0, 8'hB4};
      sweep[3] = '{3'd4, 8'h00, 1'b0, 8'hDA};
      sweep[4] = '{3'd5, 8'h00, 1'b1, 8'hED};
      sweep[5] = '{3'd6, 8'h00, 1'b0, 8'hF6};
      sweep[6] = '{3'd0, 8'h00, 1'b0, 8'h00};
      lfsr_seq = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};

      // Reset state.
      rst = 1'b1;
      tick(); tick();
      chk("rst_q", int'(q), 0);
      chk("rst_nib_hi", int'(nib_hi), 0);
      chk("rst_nib_lo", int'(nib_lo), 0);
      chk("rst_step", int'(step_o), 0);
      rst = 1'b0;
      model_q = 8'h00;
      tick();

      // Bounce then steady press held for 50 extra cycles.
      press(3'd1, 8'h3C, 1'b0, 1'b1, 62, "bounce");

      // Operation sweep.
      for (int i = 0; i < 7; i++) begin
         press(sweep[i].op, sweep[i].din, sweep[i].sin, 1'b0, 10, $sformatf("sweep%0d", i));
         chk($sformatf("sweep%0d_table", i), int'(q), int'(sweep[i].exp));
      end

      // LFSR from zero, then a full period.
      for (int i = 0; i < 6; i++) begin
         press(3'd7, 8'h00, 1'b0, 1'b0, 8, $sformatf("lfsr%0d", i));
         chk($sformatf("lfsr%0d_seq", i), int'(q), int'(lfsr_seq[i]));
      end
      saw_zero = 1'b0;
      for (int i = 0; i < 255; i++) begin
         press(3'd7, 8'h00, 1'b0, 1'b0, 7, "lfsr_period");
         if (q == 8'h00) saw_zero = 1'b1;
      end
      chk("lfsr_period_end", int'(q), 8'h88);
      chk("lfsr_no_zero", int'(saw_zero), 0);

      // Random operations with random bounce prefixes.
      for (int i = 0; i < 40; i++) begin
         press(3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 9, "rand");
      end

      // Reset while the counter is mid-count; still-held button is a fresh press.
      op = 3'd1; din = 8'hA5; sin = 1'b0;
      btn = 1'b1;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (step_o) pulses++;
      end
      rst = 1'b1;
      tick();
      if (step_o) pulses++;
      chk("midrst_no_step", pulses, 0);
      chk("midrst_q", int'(q), 0);
      rst = 1'b0;
      model_q = 8'h00;
      step_edge = -1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (step_o && step_edge < 0) step_edge = e;
      end
      chk("midrst_step_edge", step_edge, 6);
      chk("midrst_q_after", int'(q), 8'hA5);
      btn = 1'b0;
      for (int k = 0; k < 8; k++) tick();

      // Reset in the same cycle as the step pulse.
      din = 8'h3C;
      btn = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("rststep_pulse", int'(step_o), 1);
      rst = 1'b1;
      btn = 1'b0;
      tick();
      chk("rststep_q", int'(q), 0);
      chk("rststep_step", int'(step_o), 0);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (step_o) pulses++;
      end
      chk("rststep_no_pulse", pulses, 0);
      chk("rststep_q_hold", int'(q), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
